// File: rtl/float_int_conv.sv
// Multi-cycle itof/ftoi converter for the LM32 float coprocessor.
// A single working register is shifted one bit per cycle for normalisation and alignment.
module float_int_conv #(
    parameter int Nm = 23,
    parameter int Ne = 8,
    parameter int W  = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] operand,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int BIAS  = 2**(Ne-1) - 1;
    localparam int CNT_W = $clog2(W) + 1;
    localparam int WW    = W + Nm;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t            state_reg, state_next;
    logic              op_reg;
    logic              sign_reg;
    logic              special_reg;
    logic [W-1:0]      special_val_reg;
    logic [WW-1:0]     work_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  k_reg;
    logic [W-1:0]      result_reg;
    logic              done_reg;

    // Capture-side decode of the incoming operand
    logic [W-1:0]      mag_in;
    logic [CNT_W-1:0]  lz_cnt;
    logic              lz_found;
    logic              f_sign;
    logic [Ne-1:0]     f_exp;
    logic [Nm-1:0]     f_man;
    logic signed [Ne+1:0] f_u;

    logic              cap_sign;
    logic              cap_special;
    logic [W-1:0]      cap_special_val;
    logic [WW-1:0]     cap_work;
    logic [CNT_W-1:0]  cap_cnt;

    logic [Ne-1:0]     itof_exp;
    logic [W-1:0]      itof_res;
    logic [W-1:0]      ftoi_mag;
    logic [W-1:0]      ftoi_res;
    logic              unused_bits;

    assign mag_in = operand[W-1] ? -operand : operand;
    assign f_sign = operand[Ne+Nm];
    assign f_exp  = operand[Ne+Nm-1:Nm];
    assign f_man  = operand[Nm-1:0];
    assign f_u    = $signed({2'b00, f_exp}) - $signed((Ne+2)'(BIAS));

    always_comb begin
        lz_cnt   = '0;
        lz_found = 1'b0;
        for (int i = W-1; i >= 0; i--) begin
            if (!lz_found) begin
                if (mag_in[i]) lz_found = 1'b1;
                else           lz_cnt   = lz_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cap_sign        = 1'b0;
        cap_special     = 1'b0;
        cap_special_val = '0;
        cap_work        = '0;
        cap_cnt         = '0;
        if (!op) begin
            cap_sign = operand[W-1];
            if (operand == '0) begin
                cap_special = 1'b1;
            end else begin
                cap_work = WW'(mag_in);
                cap_cnt  = lz_cnt;
            end
        end else begin
            cap_sign = f_sign;
            if (f_exp == '0 || f_u < 0) begin
                cap_special = 1'b1;
            end else if ((&f_exp) || f_u > $signed((Ne+2)'(W-2))) begin
                cap_special     = 1'b1;
                cap_special_val = f_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                cap_work = WW'({1'b1, f_man});
                cap_cnt  = f_u[CNT_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start) state_next = (cap_cnt != '0) ? SHIFT : FINISH;
            SHIFT:  if (cnt_reg == CNT_W'(1)) state_next = FINISH;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_comb begin
        itof_exp = Ne'(BIAS + W - 1) - Ne'(k_reg);
        itof_res = W'({sign_reg, itof_exp, work_reg[W-2 -: Nm]});
        ftoi_mag = work_reg[WW-1:Nm];
        ftoi_res = sign_reg ? -ftoi_mag : ftoi_mag;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_reg          <= 1'b0;
            sign_reg        <= 1'b0;
            special_reg     <= 1'b0;
            special_val_reg <= '0;
            work_reg        <= '0;
            cnt_reg         <= '0;
            k_reg           <= '0;
            result_reg      <= '0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg          <= op;
                        sign_reg        <= cap_sign;
                        special_reg     <= cap_special;
                        special_val_reg <= cap_special_val;
                        work_reg        <= cap_work;
                        cnt_reg         <= cap_cnt;
                        k_reg           <= cap_cnt;
                    end
                end
                SHIFT: begin
                    work_reg <= work_reg << 1;
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                end
                FINISH: begin
                    if (special_reg)  result_reg <= special_val_reg;
                    else if (!op_reg) result_reg <= itof_res;
                    else              result_reg <= ftoi_res;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Low work_reg bits below the itof mantissa window are only meaningful for ftoi
    assign unused_bits = ^work_reg;

    assign done   = done_reg;
    assign result = result_reg;
endmodule

// File: tb/tb_float_int_conv.sv
// Directed self-checking bench for float_int_conv (Nm=23, Ne=8, W=32).
module tb_float_int_conv;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] operand = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    float_int_conv #(.Nm(23), .Ne(8), .W(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .operand(operand), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Launch one conversion and report the edge count (from E0) at which done appeared.
    task automatic do_conv(input logic o, input logic [31:0] val,
                           output int lat, output logic [31:0] res);
        @(negedge clk);
        op = o; operand = val; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; res = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i; res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=00000000", result); end
        $display("reset: busy=%b done=%b result=%h", busy, done, result);
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_itof();
        logic [31:0] vin [5]  = '{32'h00000001, 32'hFFFFFFFA, 32'h80000000, 32'h01000001, 32'h00000000};
        logic [31:0] vexp [5] = '{32'h3F800000, 32'hC0C00000, 32'hCF000000, 32'h4B800000, 32'h00000000};
        int          vlat [5] = '{32, 30, 1, 8, 1};
        int lat; logic [31:0] res;
        for (int i = 0; i < 5; i++) begin
            do_conv(1'b0, vin[i], lat, res);
            $display("itof %h -> %h latency %0d", vin[i], res, lat);
            checks++; if (lat != vlat[i]) begin failures++; $display("FAIL itof_latency[%0d] got=%0d want=%0d", i, lat, vlat[i]); end
            checks++; if (res !== vexp[i]) begin failures++; $display("FAIL itof_result[%0d] got=%h want=%h", i, res, vexp[i]); end
        end
    endtask

    task automatic test_ftoi();
        logic [31:0] vin [7]  = '{32'h40490FDB, 32'hC2F6E979, 32'h3F000000, 32'h00000000,
                                  32'h4F000000, 32'hCF800000, 32'h7F800000};
        logic [31:0] vexp [7] = '{32'h00000003, 32'hFFFFFF85, 32'h00000000, 32'h00000000,
                                  32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        int          vlat [7] = '{2, 7, 1, 1, 1, 1, 1};
        int lat; logic [31:0] res;
        for (int i = 0; i < 7; i++) begin
            do_conv(1'b1, vin[i], lat, res);
            $display("ftoi %h -> %h latency %0d", vin[i], res, lat);
            checks++; if (lat != vlat[i]) begin failures++; $display("FAIL ftoi_latency[%0d] got=%0d want=%0d", i, lat, vlat[i]); end
            checks++; if (res !== vexp[i]) begin failures++; $display("FAIL ftoi_result[%0d] got=%h want=%h", i, res, vexp[i]); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat = -1; logic [31:0] res = 'x;
        @(negedge clk);
        op = 1'b0; operand = 32'hFFFFFFFA; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (i == 5) begin op = 1'b1; operand = 32'h41200000; start = 1'b1; end
            if (i == 6) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin lat = i; res = result; break; end
        end
        start = 1'b0;
        $display("busy_ignore: itof FFFFFFFA -> %h latency %0d", res, lat);
        checks++; if (lat != 30) begin failures++; $display("FAIL busy_ignore_latency got=%0d want=30", lat); end
        checks++; if (res !== 32'hC0C00000) begin failures++; $display("FAIL busy_ignore_result got=%h want=C0C00000", res); end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        logic [31:0] r1 = 'x, r2 = 'x;
        logic b1 = 1'bx;
        @(negedge clk);
        op = 1'b1; operand = 32'h40490FDB; start = 1'b1;
        @(posedge clk); #1;
        op = 1'b0; operand = 32'h80000000;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) start = 1'b0;
            if (done && d1 < 0) begin d1 = i; r1 = result; b1 = busy; end
            else if (done && d2 < 0) begin d2 = i; r2 = result; end
        end
        $display("back_to_back: first %h at %0d, second %h at %0d", r1, d1, r2, d2);
        checks++; if (d1 != 2) begin failures++; $display("FAIL b2b_first_latency got=%0d want=2", d1); end
        checks++; if (r1 !== 32'h3) begin failures++; $display("FAIL b2b_first_result got=%h want=00000003", r1); end
        checks++; if (b1 !== 1'b0) begin failures++; $display("FAIL b2b_busy_in_done got=%b want=0", b1); end
        checks++; if (d2 != 4) begin failures++; $display("FAIL b2b_second_latency got=%0d want=4", d2); end
        checks++; if (r2 !== 32'hCF000000) begin failures++; $display("FAIL b2b_second_result got=%h want=CF000000", r2); end
    endtask

    task automatic test_reset_mid_op();
        int seen_done = 0;
        int lat; logic [31:0] res;
        @(negedge clk);
        op = 1'b0; operand = 32'h00000001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", busy); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h want=00000000", result); end
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        $display("reset_mid_op: done pulses after abort=%0d busy=%b", seen_done, busy);
        checks++; if (seen_done != 0) begin failures++; $display("FAIL midreset_no_done got=%0d want=0", seen_done); end
        do_conv(1'b1, 32'h41200000, lat, res);
        $display("ftoi 41200000 -> %h latency %0d", res, lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL midreset_next_latency got=%0d want=4", lat); end
        checks++; if (res !== 32'd10) begin failures++; $display("FAIL midreset_next_result got=%h want=0000000A", res); end
    endtask

    initial begin
        test_reset();
        test_itof();
        test_ftoi();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
